// File: rtl/prv32_pkg.sv
// Shared RV32I issue-stage definitions: opcodes, ALU function codes, the
// decoded-entry bundle and immediate extraction helpers.
package prv32_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_PASS_B = 4'b0011,
        ALU_OR     = 4'b0100,
        ALU_AND    = 4'b0101,
        ALU_XOR    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SLL    = 4'b1001,
        ALU_SRA    = 4'b1010,
        ALU_SLT    = 4'b1101,
        ALU_SLTU   = 4'b1111
    } alufn_e;

    typedef struct packed {
        alufn_e      alufn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        wr_en;
        logic        is_branch;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic        illegal;
    } issue_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // alt selects sub/sra; callers only raise it where funct7 may legally carry it.
    function automatic alufn_e alu_for_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic issue_t empty_entry(input logic [31:0] pc);
        issue_t e;
        e    = '0;
        e.pc = pc;
        return e;
    endfunction

endpackage

// File: rtl/prv32_issue_decode.sv
// Combinational RV32I decode: instruction, PC and operands into one ALU
// issue bundle. Undecodable words become a zeroed entry flagged illegal.
module prv32_issue_decode
    import prv32_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output issue_t      dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_shift;
    logic       bad;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rd       = instr[11:7];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec    = empty_entry(pc);
        bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.alufn = alu_for_funct3(funct3, funct7 == F7_ALT);
                dec.a     = rs1;
                dec.b     = rs2;
                dec.rd    = rd;
                dec.wr_en = 1'b1;
                if (is_shift) dec.shamt = rs2[4:0];
                bad = !((funct7 == F7_BASE) ||
                        (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                // funct7 bits belong to the immediate except on right shifts.
                dec.alufn = alu_for_funct3(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
                dec.a     = rs1;
                dec.b     = imm_i(instr);
                dec.rd    = rd;
                dec.wr_en = 1'b1;
                if (is_shift) dec.shamt = instr[24:20];
                bad = (funct3 == 3'b001 && funct7 != F7_BASE) ||
                      (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT);
            end
            OPC_LUI: begin
                dec.alufn = ALU_PASS_B;
                dec.b     = imm_u(instr);
                dec.rd    = rd;
                dec.wr_en = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alufn = ALU_ADD;
                dec.a     = pc;
                dec.b     = imm_u(instr);
                dec.rd    = rd;
                dec.wr_en = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alufn     = ALU_SUB;
                dec.a         = rs1;
                dec.b         = rs2;
                dec.is_branch = 1'b1;
                dec.funct3    = funct3;
                bad           = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD, OPC_JALR: begin
                dec.alufn = ALU_ADD;
                dec.a     = rs1;
                dec.b     = imm_i(instr);
                dec.rd    = rd;
                dec.wr_en = 1'b1;
                if (opcode == OPC_LOAD) dec.funct3 = funct3;
            end
            OPC_STORE: begin
                dec.alufn  = ALU_ADD;
                dec.a      = rs1;
                dec.b      = imm_s(instr);
                dec.funct3 = funct3;
            end
            OPC_JAL: begin
                dec.alufn = ALU_ADD;
                dec.a     = pc;
                dec.b     = imm_j(instr);
                dec.rd    = rd;
                dec.wr_en = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec         = empty_entry(pc);
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0) dec.wr_en = 1'b0;
    end

endmodule

// File: rtl/prv32_alu_issue.sv
// RV32I decode/issue stage: decodes the offered instruction and parks it in a
// 2-entry skid buffer (head + skid slot) feeding execute over valid/ready.
module prv32_alu_issue
    import prv32_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC_FIELD = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alufn,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_shamt,
    output logic [4:0]      out_rd,
    output logic            out_wr_en,
    output logic            out_is_branch,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

    state_e state;
    issue_t dec;
    issue_t head;
    issue_t skid;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   pop;

    prv32_issue_decode u_decode (
        .instr (in_instr),
        .pc    (in_pc),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .dec   (dec)
    );

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // NOTE: both slots are reset, not just the state, because the head drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            head        <= empty_entry(RESET_PC_FIELD);
            skid        <= empty_entry(RESET_PC_FIELD);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state       <= S_EMPTY;
            head        <= empty_entry(RESET_PC_FIELD);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees the pre-edge state.
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        head        <= dec;
                        state       <= S_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid       <= dec;
                            state      <= S_FULL;
                            in_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            head        <= empty_entry(RESET_PC_FIELD);
                            state       <= S_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                        2'b11:   head <= dec;
                        default: ;
                    endcase
                end
                S_FULL: begin
                    if (pop) begin
                        head       <= skid;
                        state      <= S_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_alufn     = head.alufn;
    assign out_a         = head.a;
    assign out_b         = head.b;
    assign out_shamt     = head.shamt;
    assign out_rd        = head.rd;
    assign out_wr_en     = head.wr_en;
    assign out_is_branch = head.is_branch;
    assign out_funct3    = head.funct3;
    assign out_pc        = head.pc;
    assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_prv32_alu_issue.sv
// Self-checking bench for prv32_alu_issue: directed decode/handshake steps,
// then randomized traffic scored against a queue-based reference model.
module tb_prv32_alu_issue;

    localparam logic [31:0] RST_PC = 32'h0000_0ABC;

    // ALU code indexed by funct3 when funct7 carries no alternate bit.
    localparam logic [3:0] FN_BY_F3 [8] = '{4'h0, 4'h9, 4'hD, 4'hF, 4'h7, 4'h8, 4'h4, 4'h5};

    typedef struct {
        logic [3:0]  alufn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic        wr_en;
        logic        is_branch;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic        illegal;
        bit          chk_data;
        bit          chk_rd;
        bit          chk_f3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic [3:0]  out_alufn;
    logic [31:0] out_a, out_b, out_pc;
    logic [4:0]  out_shamt, out_rd;
    logic        out_wr_en, out_is_branch, out_illegal;
    logic [2:0]  out_funct3;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    prv32_alu_issue #(.XLEN(32), .RESET_PC_FIELD(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready), .out_alufn(out_alufn),
        .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt), .out_rd(out_rd),
        .out_wr_en(out_wr_en), .out_is_branch(out_is_branch),
        .out_funct3(out_funct3), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1; in_instr = i; in_pc = p; in_rs1 = r1; in_rs2 = r2;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Reference decode straight from the RV32I field rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, u_imm, j_imm;
        bit          shift;
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = (i_imm & ~32'h1F) | {27'd0, ins[11:7]};
        u_imm = ins & 32'hFFFF_F000;
        j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e = '{alufn: 4'h0, a: 0, b: 0, shamt: 0, rd: ins[11:7], wr_en: 0, is_branch: 0,
              funct3: f3, pc: pc, illegal: 0, chk_data: 1, chk_rd: 0, chk_f3: 0};
        case (op)
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    e.alufn = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'h1 : 4'hA) : FN_BY_F3[f3];
                    e.a = rs1; e.b = rs2; e.wr_en = 1; e.chk_rd = 1;
                    e.shamt = shift ? rs2[4:0] : 5'd0;
                end else begin
                    e.illegal = 1; e.chk_data = 0;
                end
            end
            7'h13: begin
                if ((f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
                    e.illegal = 1; e.chk_data = 0;
                end else begin
                    e.alufn = (f3 == 3'd5 && f7 == 7'h20) ? 4'hA : FN_BY_F3[f3];
                    e.a = rs1; e.b = i_imm; e.wr_en = 1; e.chk_rd = 1;
                    e.shamt = shift ? ins[24:20] : 5'd0;
                end
            end
            7'h37: begin e.alufn = 4'h3; e.b = u_imm; e.wr_en = 1; e.chk_rd = 1; end
            7'h17: begin e.a = pc; e.b = u_imm; e.wr_en = 1; e.chk_rd = 1; end
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    e.illegal = 1; e.chk_data = 0;
                end else begin
                    e.alufn = 4'h1; e.a = rs1; e.b = rs2; e.is_branch = 1; e.chk_f3 = 1;
                end
            end
            7'h03: begin e.a = rs1; e.b = i_imm; e.wr_en = 1; e.chk_rd = 1; e.chk_f3 = 1; end
            7'h67: begin e.a = rs1; e.b = i_imm; e.wr_en = 1; e.chk_rd = 1; end
            7'h23: begin e.a = rs1; e.b = s_imm; e.chk_f3 = 1; end
            7'h6F: begin e.a = pc; e.b = j_imm; e.wr_en = 1; e.chk_rd = 1; end
            default: e.illegal = 1;
        endcase
        if (ins[11:7] == 5'd0) e.wr_en = 0;
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        logic [6:0]  f7;
        r  = $urandom;
        f3 = r[14:12];
        f7 = r[30] ? 7'h20 : 7'h00;
        case ($urandom_range(0, 11))
            0:  return {((f3 == 3'd0 || f3 == 3'd5) ? f7 : 7'h00), r[24:15], f3, r[11:7], 7'h33};
            1:  begin
                    if (f3 == 3'd1) return {7'h00, r[24:15], f3, r[11:7], 7'h13};
                    if (f3 == 3'd5) return {f7, r[24:15], f3, r[11:7], 7'h13};
                    return {r[31:15], f3, r[11:7], 7'h13};
                end
            2:  return {r[31:7], 7'h37};
            3:  return {r[31:7], 7'h17};
            4:  return {r[31:15], ((f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3), r[11:7], 7'h63};
            5:  return {r[31:7], 7'h03};
            6:  return {r[31:15], 3'd0, r[11:7], 7'h67};
            7:  return {r[31:7], 7'h23};
            8:  return {r[31:7], 7'h6F};
            9:  return {r[31:7], r[6:2], 2'b10};
            10: return {r[31:15], 2'b01, r[12], r[11:7], 7'h63};
            default: return {7'h01, r[24:15], f3, r[11:7], 7'h33};
        endcase
    endfunction

    task automatic check_head(input exp_t e);
        check("rnd.illegal", out_illegal, e.illegal);
        check("rnd.pc", out_pc, e.pc);
        if (e.chk_data) begin
            check("rnd.alufn", out_alufn, e.alufn);
            check("rnd.a", out_a, e.a);
            check("rnd.b", out_b, e.b);
            check("rnd.shamt", out_shamt, e.shamt);
            check("rnd.wr_en", out_wr_en, e.wr_en);
            check("rnd.is_branch", out_is_branch, e.is_branch);
        end
        if (e.chk_rd) check("rnd.rd", out_rd, e.rd);
        if (e.chk_f3) check("rnd.funct3", out_funct3, e.funct3);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;

        // Reset state
        #12;
        check("rst.out_valid", out_valid, 0);
        check("rst.in_ready", in_ready, 1);
        check("rst.alufn", out_alufn, 0);
        check("rst.a", out_a, 0);
        check("rst.wr_en", out_wr_en, 0);
        check("rst.pc", out_pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add x3,x1,x2
        put(32'h002081B3, 32'h40, 32'd5, 32'd7);
        check("add.out_valid", out_valid, 1);
        check("add.alufn", out_alufn, 4'h0);
        check("add.a", out_a, 5);
        check("add.b", out_b, 7);
        check("add.rd", out_rd, 3);
        check("add.wr_en", out_wr_en, 1);
        check("add.shamt", out_shamt, 0);
        check("add.pc", out_pc, 32'h40);
        drain();
        check("pop.out_valid", out_valid, 0);
        check("pop.pc", out_pc, RST_PC);

        put(32'h402081B3, 32'h44, 32'd5, 32'd7);
        check("sub.alufn", out_alufn, 4'h1);
        check("sub.a", out_a, 5);
        check("sub.b", out_b, 7);
        drain();

        put(32'h40335293, 32'h48, 32'h8000_0000, 32'h0);
        check("srai.alufn", out_alufn, 4'hA);
        check("srai.shamt", out_shamt, 3);
        check("srai.rd", out_rd, 5);
        check("srai.a", out_a, 32'h8000_0000);
        check("srai.b", out_b, 32'h403);
        drain();

        put(32'h123450B7, 32'h4C, 32'hFFFF_FFFF, 32'h1);
        check("lui.alufn", out_alufn, 4'h3);
        check("lui.a", out_a, 0);
        check("lui.b", out_b, 32'h1234_5000);
        drain();

        put(32'h00001097, 32'h100, 32'h0, 32'h0);
        check("auipc.alufn", out_alufn, 4'h0);
        check("auipc.a", out_a, 32'h100);
        check("auipc.b", out_b, 32'h1000);
        drain();

        put(32'h0000_0000, 32'h200, 32'hDEAD, 32'hBEEF);
        check("ill.illegal", out_illegal, 1);
        check("ill.wr_en", out_wr_en, 0);
        check("ill.alufn", out_alufn, 0);
        check("ill.a", out_a, 0);
        check("ill.b", out_b, 0);
        check("ill.is_branch", out_is_branch, 0);
        drain();

        put(32'h00100013, 32'h204, 32'h0, 32'h0);
        check("addi_x0.illegal", out_illegal, 0);
        check("addi_x0.wr_en", out_wr_en, 0);
        check("addi_x0.b", out_b, 1);
        drain();

        // Backpressure: three back-to-back offers with execute stalled
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h10;
        tick();
        check("bp.ready1", in_ready, 1);
        check("bp.head1", out_rd, 1);
        in_instr = 32'h00200113; in_pc = 32'h14;
        tick();
        check("bp.ready2", in_ready, 0);
        check("bp.stable_rd", out_rd, 1);
        in_instr = 32'h00300193; in_pc = 32'h18;
        tick();
        check("bp.ready3", in_ready, 0);
        check("bp.stable_pc", out_pc, 32'h10);
        out_ready = 1'b1;
        tick();
        check("bp.second_rd", out_rd, 2);
        check("bp.second_pc", out_pc, 32'h14);
        check("bp.ready4", in_ready, 1);
        tick();
        check("bp.third_rd", out_rd, 3);
        check("bp.third_b", out_b, 3);
        in_valid = 1'b0;
        tick();
        check("bp.empty", out_valid, 0);
        out_ready = 1'b0;

        // Flush while FULL
        put(32'h00100093, 32'h20, 0, 0);
        put(32'h00200113, 32'h24, 0, 0);
        check("fl.full", in_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl.out_valid", out_valid, 0);
        check("fl.in_ready", in_ready, 1);
        check("fl.pc", out_pc, RST_PC);

        // Flush drops a same-cycle offer
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_drop.now", out_valid, 0);
        tick();
        check("fl_drop.later", out_valid, 0);

        // Reset mid-transfer while FULL
        put(32'h00100093, 32'h30, 0, 0);
        put(32'h00200113, 32'h34, 0, 32'h0);
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mrst.out_valid", out_valid, 0);
        check("mrst.in_ready", in_ready, 1);
        check("mrst.a", out_a, 0);
        check("mrst.b", out_b, 0);
        check("mrst.rd", out_rd, 0);
        check("mrst.pc", out_pc, RST_PC);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        tick();

        // Randomized traffic against the queue model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            in_pc     = $urandom & ~32'h3;
            in_rs1    = $urandom;
            in_rs2    = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            check("rnd.out_valid", out_valid, (q.size() != 0));
            check("rnd.in_ready", in_ready, (q.size() < 2));
            if (q.size() != 0) check_head(q[0]);
            else check("rnd.empty_pc", out_pc, RST_PC);
            if (flush) begin
                q.delete();
            end else begin
                n = q.size();
                if (n != 0 && out_ready) void'(q.pop_front());
                if (in_valid && n < 2) q.push_back(model(in_instr, in_pc, in_rs1, in_rs2));
            end
            tick();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (q.size() != 0) begin
                check_head(q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        check("end.out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/prv32_alu_issue.md
Name: prv32_alu_issue

Overview:
- Decode/issue stage that drives the RV32I ALU. Accepts a fetched instruction with its PC and register-file operands over a valid/ready handshake.
- Translates the instruction into ALU controls (alufn, a, b, shamt) plus writeback and branch side-band.
- Registers everything into a 2-entry skid buffer feeding the execute stage over valid/ready.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC_FIELD, 32'h0, value driven on out_pc while empty

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  instruction offered
- in_ready  output  1  stage can accept
- in_instr  input  32  instruction word
- in_pc  input  32  instruction PC
- in_rs1  input  32  rs1 data
- in_rs2  input  32  rs2 data
- out_valid  output  1  head entry valid
- out_ready  input  1  execute accepts head
- out_alufn  output  4  ALU function code
- out_a  output  32  ALU operand a
- out_b  output  32  ALU operand b
- out_shamt  output  5  shift amount
- out_rd  output  5  destination register
- out_wr_en  output  1  writeback enable
- out_is_branch  output  1  conditional branch
- out_funct3  output  3  branch/memory funct3
- out_pc  output  32  PC of head entry
- out_illegal  output  1  undecodable instruction

Behaviour:
- Reset (rst_n low, async): buffer EMPTY. out_valid=0, in_ready=1, all out_* data=0, out_pc=RESET_PC_FIELD.
- Buffer states: EMPTY, ONE, FULL.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready is registered and equals (state != FULL).
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N (one cycle).
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without pop -> FULL; second entry goes to the skid slot.
  - ONE + pop without accept -> EMPTY.
  - ONE + accept + pop -> ONE, new entry becomes head.
  - FULL + pop -> ONE, skid slot moves to head. No accept is possible in FULL.
- Order is strictly FIFO. Head outputs are stable while out_valid & ~out_ready.
- flush has priority over accept and pop: state -> EMPTY, in_ready=1 next cycle, the same-cycle input is dropped.
- Reset mid-transfer drops all entries.
- alufn encoding (fixed):
  - 0000 add, 0001 sub, 0011 pass b
  - 0100 or, 0101 and, 0111 xor
  - 1000 srl, 1001 sll, 1010 sra
  - 1101 slt, 1111 sltu
  - 0010 and 0110 are never issued. LUI and AUIPC use pre-shifted immediates.
- Decode:
  - OP (0110011): a=rs1, b=rs2, shamt=rs2[4:0]. funct7 must be 0, or 0100000 only for funct3 000/101; any other funct7 -> illegal. wr_en=1.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm, shamt=instr[24:20]. funct3 000 is always add. slli requires funct7=0. srli/srai require funct7 0/0100000. wr_en=1.
  - LUI: alufn 0011, a=0, b={instr[31:12],12'b0}, wr_en=1.
  - AUIPC: alufn 0000, a=pc, b=U-imm, wr_en=1.
  - BRANCH: alufn 0001, a=rs1, b=rs2, is_branch=1, funct3 passed through. funct3 010/011 -> illegal.
  - LOAD/JALR: alufn 0000, a=rs1, b=I-imm. wr_en=1.
  - STORE: alufn 0000, a=rs1, b=S-imm. wr_en=0.
  - JAL: alufn 0000, a=pc, b=J-imm. wr_en=1.
- wr_en is forced to 0 when rd=0.
- Any other opcode: illegal=1, alufn 0000, a=b=0, wr_en=0, is_branch=0. Illegal entries still flow through the buffer.
- shamt is 0 for every non-shift instruction.

Decomposition:
- Shared package prv32_pkg: opcode constants, alufn constants, immediate-extraction functions (I/S/B/U/J).
- One combinational sub-module, prv32_issue_decode (instr, pc, rs1, rs2 -> decoded bundle). The top module holds the skid buffer and state machine.

Test Plan:
- add 0x002081B3, rs1=5, rs2=7 -> alufn 0000, a=5, b=7, rd=3, wr_en=1, out_valid one cycle after accept.
- sub 0x402081B3 -> alufn 0001. srai 0x40335293, rs1=0x80000000 -> alufn 1010, shamt=3, rd=5.
- LUI 0x123450B7 -> alufn 0011, a=0, b=0x12345000. AUIPC with pc=0x100 and imm 1 -> a=0x100, b=0x1000.
- Backpressure: out_ready=0, three back-to-back offers -> in_ready falls after two accepts, third held. Release -> FIFO order preserved, no loss or duplication.
- Illegal 0x00000000 and addi x0 (0x00100013) -> illegal=1 for the first; wr_en=0 for both.
- Flush and reset while FULL: flush -> out_valid=0 next cycle; asserting rst_n low mid-transfer -> immediate out_valid=0, in_ready=1, outputs zeroed.
